// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter of the multi-cycle MIPS core.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, loader and memory-side signals around the memory port arbiter.
interface mem_port_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        output ldr_ack, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output owner
    );

    // Requester / memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        input  ldr_ack, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  owner
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way request picker: round-robin on ties, or loader-first when
// ARB_LDR_PRIORITY_EN is defined. req[0]/gnt[0] = CPU, req[1]/gnt[1] = loader.
module rr_pick2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
`ifdef ARB_LDR_PRIORITY_EN
            gnt = 2'b10;
`else
            gnt = (last_gnt == OWNER_LDR) ? 2'b01 : 2'b10;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU and loader onto the single unified memory with a fixed MEM_LAT access.
// Optional build macro: ARB_LDR_PRIORITY_EN (loader wins ties; handled in rr_pick2).
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              in_reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    arb_state_t    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic [1:0]    gnt;
    logic          cpu_ack;
    logic          ldr_ack;

    rr_pick2 u_pick (
        .req      ({bus.ldr_req, bus.cpu_req}),
        .last_gnt (last_gnt_q),
        .gnt      (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    last_gnt_d  = gnt[1] ? OWNER_LDR : OWNER_CPU;
                    mem_we_d    = gnt[1] ? bus.ldr_we    : bus.cpu_we;
                    mem_addr_d  = gnt[1] ? bus.ldr_addr  : bus.cpu_addr;
                    mem_wdata_d = gnt[1] ? bus.ldr_wdata : bus.cpu_wdata;
                    cnt_d       = 4'd0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    // Writes leave the requester's read-data register untouched.
                    if (!mem_we_q) begin
                        if (last_gnt_q == OWNER_LDR) ldr_rdata_d = bus.mem_rdata;
                        else                         cpu_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_gnt_q  <= OWNER_LDR;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    // Decoded straight from state flops so reset drops mem_en and the acks at once.
    assign cpu_ack       = (state_q == RESP) && (last_gnt_q == OWNER_CPU);
    assign ldr_ack       = (state_q == RESP) && (last_gnt_q == OWNER_LDR);
    assign bus.cpu_ack   = cpu_ack;
    assign bus.ldr_ack   = ldr_ack;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) & mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = last_gnt_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle MIPS core between two requesters: the CPU datapath (fetch, lw, sw) and the program loader/debug port.
- Sits between the requesters and the memory. Sequences each access over a fixed memory latency and returns a one-cycle ack.
- Exports cpu_stall so the main control FSM freezes its state while it waits for memory.

Parameters:
- AW, 8, address width in words.
- DW, 32, data width.
- MEM_LAT, 2, memory read/write latency in cycles. Legal range 1..15.

Ports:
- clk  in  1  clock.
- in_reset  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request. Held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Stable while cpu_req is high.
- cpu_addr  in  AW  CPU address. Stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DW  read data. Valid in the cpu_ack cycle.
- cpu_stall  out  1  cpu_req & ~cpu_ack. Combinational.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/AW/DW  loader request. Same rules as the CPU signals.
- ldr_ack  out  1  one-cycle completion pulse to the loader.
- ldr_rdata  out  DW  read data. Valid in the ldr_ack cycle.
- mem_en  out  1  memory enable. High for the whole ACCESS phase.
- mem_we  out  1  memory write enable. Qualified by mem_en.
- mem_addr  out  AW  memory address. Registered.
- mem_wdata  out  DW  memory write data. Registered.
- mem_rdata  in  DW  memory read data. Valid MEM_LAT cycles after mem_en first rises, with the address held.
- owner  out  1  current or last grantee: 0 = CPU, 1 = loader.

Behaviour:
- Reset values:
  - State IDLE.
  - mem_en = mem_we = 0; mem_addr = mem_wdata = 0.
  - cpu_ack = ldr_ack = 0; cpu_rdata = ldr_rdata = 0.
  - cnt = 0.
  - last_gnt = loader, so the CPU wins the first tie. owner = last_gnt.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE with all outputs quiescent.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is NOT last_gnt (round-robin).
  - On grant: latch the winner's we, addr and wdata into the mem_* registers, set owner and last_gnt, cnt <= 0, go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_we = latched we.
  - cnt increments every cycle.
  - When cnt == MEM_LAT-1: capture mem_rdata into the owner's rdata register, go to RESP.
  - ACCESS lasts exactly MEM_LAT cycles.
- RESP:
  - mem_en = 0. Pulse the owner's ack for one cycle. Go to IDLE.
  - Write acks leave the rdata register unchanged.
- Latency: request seen in IDLE at cycle t produces ack at cycle t+MEM_LAT+1. The arbiter is back in IDLE at t+MEM_LAT+2.
- Back-to-back: a requester that keeps req high after its ack is re-arbitrated in the next IDLE cycle.
  - With both requesting continuously, grants alternate CPU, loader, CPU, ...
  - Minimum spacing between acks is MEM_LAT+2 cycles.
- Request withdrawn during ACCESS (protocol violation): the access still completes and is acked. The arbiter never aborts a memory access.
- The non-owner's inputs are ignored outside IDLE, and the non-owner's ack stays 0.
- Asynchronous reset mid-access:
  - Immediately returns to IDLE; mem_en drops in the reset cycle.
  - No ack is produced; the in-flight transaction is lost.
  - last_gnt returns to loader.
- cnt width is 4 bits, so it never wraps within the legal MEM_LAT range.

Optional Feature:
- Macro: ARB_LDR_PRIORITY_EN.
- Defined: the loader has fixed priority. When both request in IDLE, the loader always wins; last_gnt is still updated but ignored for selection.
- Not defined: round-robin as described in Behaviour.
- Timing, handshake and reset behaviour are identical in both builds.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the arb_state_t enum (IDLE, ACCESS, RESP);
  - owner constants OWNER_CPU = 1'b0 and OWNER_LDR = 1'b1;
  - default AW and DW constants.
- One natural sub-module: rr_pick2. It is a combinational 2-way picker taking req[1:0] and last_gnt, and returning a gnt one-hot.
- The ARB_LDR_PRIORITY_EN override lives inside rr_pick2.

Test Plan:
- Reset check: assert in_reset mid-ACCESS. Expect mem_en = 0 immediately, no ack, and state IDLE after release.
- Single CPU read, MEM_LAT=2: cpu_req with cpu_addr = 8'h10 and mem returning 32'hDEADBEEF. Expect mem_en high for 2 cycles, cpu_ack at t+3 with cpu_rdata = 32'hDEADBEEF, and cpu_stall high for cycles t..t+2.
- Loader write: ldr_we = 1, ldr_addr = 8'h04, ldr_wdata = 32'h2002000A. Expect mem_we = 1 with mem_addr = 8'h04 for 2 cycles, ldr_ack at t+3, ldr_rdata unchanged.
- Simultaneous requests from reset, both held high for 4 transactions. Expect grant order CPU, LDR, CPU, LDR and acks spaced 4 cycles apart (MEM_LAT = 2).
- Same stimulus built with ARB_LDR_PRIORITY_EN defined: the loader is granted every time and the CPU stays stalled until ldr_req drops.
- MEM_LAT=1 build: CPU read acked at t+2. cpu_req dropped during ACCESS is still acked once with no extra access.
